mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Multi-cycle MIPS control unit FSM that drives the multi-cycle datapath control inputs (IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, RegWrite, MemtoReg, RegDst, ALUControl). It decodes Op/Funct from the datapath and sequences each instruction through fetch, decode, execute, memory and writeback states. Relative to the hand-driven control sequence used today, it adds:
- a memory-ready wait handshake
- an instruction counter
- addi support
- illegal-opcode flagging

Parameters:
ALUCTRL_W, 3, width of ALUControl
PCSRC_W, 2, width of PCSrc (bit1 used only for jump)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
Op  in  6  instruction opcode from datapath
Funct  in  6  R-type function field
Zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
IorD  out  1  0=PC address, 1=ALUOut address
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
PCWrite  out  1  unconditional PC write
Branch  out  1  conditional branch cycle
PCEn  out  1  PCWrite | (Branch & Zero)
PCSrc  out  PCSRC_W  00=ALUResult, 01=ALUOut, 10=jump target
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
RegWrite  out  1  register file write
MemtoReg  out  1  1=write Data, 0=ALUOut
RegDst  out  1  1=rd, 0=rt
ALUControl  out  ALUCTRL_W  ALU operation
illegal  out  1  one-cycle pulse on unsupported opcode/funct
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst=0).
- Reset state:
  - state=FETCH, instr_cnt=0.
  - All registered outputs are 0.
  - Outputs are Moore-decoded from state, except PCEn and the mem_ready-qualified strobes.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010 (j only with JUMP_EN).
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the cycle mem_ready=1, then go to DECODE.
  - While mem_ready=0, stay in FETCH with no strobes.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010. Next state by Op:
  - lw/sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - otherwise pulse illegal and return to FETCH
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: IorD=1. Wait for mem_ready=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWR:
  - IorD=1; MemWrite=1 held every cycle until mem_ready=1.
  - Then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct:
  - 100000 -> 010 (add)
  - 100010 -> 110 (sub)
  - 100100 -> 000 (and)
  - 100101 -> 001 (or)
  - 101010 -> 111 (slt)
  - other funct: pulse illegal, return to FETCH, no writeback
  - valid funct -> ALUWB
- ALUWB: RegWrite=1, MemtoReg=0, RegDst=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=110, Branch=1, PCSrc=01. Go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Go to ADDIWB.
- ADDIWB: RegWrite=1, MemtoReg=0, RegDst=0. Go to FETCH.
- instr_cnt:
  - Increments (wrapping modulo 2^CNT_W) on the last cycle of each completed instruction: MEMWB, MEMWR with mem_ready, ALUWB, BRANCH, ADDIWB, JUMP.
  - Illegal instructions are not counted.
- Reset mid-instruction aborts immediately to FETCH; no partial write strobe survives.
- Unused state encodings recover to FETCH.

Optional Feature:
JUMP_EN
- Defined:
  - Op 000010 goes DECODE -> JUMP.
  - JUMP asserts PCSrc=10 and PCWrite=1, then goes to FETCH; the instruction is counted.
- Undefined:
  - JUMP state is absent; Op 000010 is illegal (illegal pulse, no PC write).
  - PCSrc bit1 is tied to 0.

Test Plan:
- Reset: rst=0 mid-EXEC -> all strobes 0, instr_cnt=0, FETCH on release.
- add (Op=0, Funct=100000), mem_ready=1:
  - FETCH->DECODE->EXEC->ALUWB, 4 cycles.
  - ALUControl=010 in EXEC; RegWrite=1, RegDst=1 in ALUWB; instr_cnt=1.
- lw with mem_ready low 3 cycles in MEMRD:
  - 8 total cycles, IorD=1 throughout MEMRD.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- sw with mem_ready low 2 cycles:
  - MemWrite=1 for exactly 3 cycles, then FETCH; instr_cnt increments once.
- beq, Zero=1 then Zero=0:
  - BRANCH PCEn=1 then PCEn=0.
  - PCSrc=01, ALUControl=110 in both cases.
- Op=111111 -> illegal=1 for one cycle in DECODE, FETCH next, instr_cnt unchanged.
- Op=000010:
  - With JUMP_EN: PCSrc=10, PCWrite=1.
  - Without JUMP_EN: illegal=1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// waits on mem_ready for memory accesses, counts retired instructions and flags
// unsupported opcodes/functs.
// Optional feature macro: JUMP_EN (adds the JUMP state for Op 000010).
module mips_multicycle_ctrl #(
  parameter int ALUCTRL_W = 3,
  parameter int PCSRC_W   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           Op,
  input  logic [5:0]           Funct,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 PCEn,
  output logic [PCSRC_W-1:0]   PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 RegWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instr_cnt
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
`ifdef JUMP_EN
  localparam logic [3:0] S_JUMP   = 4'd11;
`endif

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J    = 6'b000010;
`endif

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  logic             fn_ok;
  logic [ALUCTRL_W-1:0] alu_fn;

  assign instr_cnt = cnt_q;

  // R-type funct to ALU operation; unknown funct is flagged in EXEC
  always_comb begin
    fn_ok  = 1'b1;
    alu_fn = ALUCTRL_W'(3'b010);
    case (Funct)
      6'b100000: alu_fn = ALUCTRL_W'(3'b010);
      6'b100010: alu_fn = ALUCTRL_W'(3'b110);
      6'b100100: alu_fn = ALUCTRL_W'(3'b000);
      6'b100101: alu_fn = ALUCTRL_W'(3'b001);
      6'b101010: alu_fn = ALUCTRL_W'(3'b111);
      default:   fn_ok  = 1'b0;
    endcase
  end

  // State and retired-instruction counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state sequencing and counter increment
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = fn_ok ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + CNT_W'(retire);
  end

  // Moore datapath controls; strobes forced low while reset is held
  always_comb begin
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = '0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    RegWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegDst     = 1'b0;
    ALUControl = ALUCTRL_W'(3'b010);
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        illegal = !(Op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI
`ifdef JUMP_EN
                               , OP_J
`endif
                               });
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = alu_fn;
        illegal    = !fn_ok;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALUCTRL_W'(3'b110);
        Branch     = 1'b1;
        PCSrc      = PCSRC_W'(2'b01);
        retire     = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
`ifdef JUMP_EN
      S_JUMP: begin
        PCSrc   = PCSRC_W'(2'b10);
        PCWrite = 1'b1;
        retire  = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!rst) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      Branch   = 1'b0;
      illegal  = 1'b0;
    end
    PCEn = PCWrite | (Branch & Zero);
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is expanded into a list of
// expected per-cycle control vectors; a single compare process checks the DUT
// against the head of that list on every falling edge.
module tb_mips_multicycle_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic [5:0]  Op = '0, Funct = '0;
  logic        Zero = 1'b0, mem_ready = 1'b0;
  logic        IorD, MemWrite, IRWrite, PCWrite, Branch, PCEn;
  logic [1:0]  PCSrc, ALUSrcB;
  logic        ALUSrcA, RegWrite, MemtoReg, RegDst, illegal;
  logic [2:0]  ALUControl;
  logic [15:0] instr_cnt;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .RegDst(RegDst), .ALUControl(ALUControl),
    .illegal(illegal), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  // One expected cycle: control values, whether it waits on mem_ready, whether
  // finishing it retires the instruction, and how many not-ready cycles to apply.
  typedef struct {
    bit iord, memw, irw, pcw, br;
    bit [1:0] pcsrc;
    bit srca;
    bit [1:0] srcb;
    bit [2:0] alu;
    bit alu_x;
    bit regw, m2r, rdst, ill;
    bit waits, cnt;
    int stall;
  } step_t;

  step_t       q[$];
  step_t       ex;
  bit          ex_pcen;
  bit          chk_en = 1'b0;
  logic [15:0] cnt_m = '0;
  int          stall;
  int          tests = 0, fails = 0;
  int          mw_seen, ill_seen, bt_seen;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("IorD", 32'(IorD), 32'(ex.iord));
      chk("MemWrite", 32'(MemWrite), 32'(ex.memw));
      chk("IRWrite", 32'(IRWrite), 32'(ex.irw));
      chk("PCWrite", 32'(PCWrite), 32'(ex.pcw));
      chk("Branch", 32'(Branch), 32'(ex.br));
      chk("PCEn", 32'(PCEn), 32'(ex_pcen));
      chk("PCSrc", 32'(PCSrc), 32'(ex.pcsrc));
      chk("ALUSrcA", 32'(ALUSrcA), 32'(ex.srca));
      chk("ALUSrcB", 32'(ALUSrcB), 32'(ex.srcb));
      if (!ex.alu_x) chk("ALUControl", 32'(ALUControl), 32'(ex.alu));
      chk("RegWrite", 32'(RegWrite), 32'(ex.regw));
      chk("MemtoReg", 32'(MemtoReg), 32'(ex.m2r));
      chk("RegDst", 32'(RegDst), 32'(ex.rdst));
      chk("illegal", 32'(illegal), 32'(ex.ill));
      chk("instr_cnt", 32'(instr_cnt), 32'(cnt_m));
      if (MemWrite === 1'b1) mw_seen++;
      if (illegal === 1'b1) ill_seen++;
      if (Branch === 1'b1 && PCEn === 1'b1) bt_seen++;
    end
  end

  function automatic step_t blank();
    step_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit op_supported(input logic [5:0] op);
`ifdef JUMP_EN
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
`else
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
`endif
  endfunction

  function automatic void alu_of(input logic [5:0] fn, output bit ok, output bit [2:0] alu);
    ok = 1'b1;
    case (fn)
      6'b100000: alu = 3'd2;
      6'b100010: alu = 3'd6;
      6'b100100: alu = 3'd0;
      6'b100101: alu = 3'd1;
      6'b101010: alu = 3'd7;
      default: begin ok = 1'b0; alu = 3'd0; end
    endcase
  endfunction

  // Expand one instruction into its expected cycle list
  function automatic void build(input logic [5:0] op, input logic [5:0] fn,
                                input int st_f, input int st_m);
    step_t s;
    bit ok;
    bit [2:0] alu;
    s = blank(); s.srcb = 2'd1; s.alu = 3'd2; s.irw = 1; s.pcw = 1;
    s.waits = 1; s.stall = st_f;
    q.push_back(s);
    s = blank(); s.srcb = 2'd3; s.alu = 3'd2; s.ill = !op_supported(op);
    q.push_back(s);
    if (!op_supported(op)) return;
    case (op)
      OP_LW, OP_SW: begin
        s = blank(); s.srca = 1; s.srcb = 2'd2; s.alu = 3'd2; q.push_back(s);
        if (op == OP_LW) begin
          s = blank(); s.alu = 3'd2; s.iord = 1; s.waits = 1; s.stall = st_m; q.push_back(s);
          s = blank(); s.alu = 3'd2; s.regw = 1; s.m2r = 1; s.cnt = 1; q.push_back(s);
        end else begin
          s = blank(); s.alu = 3'd2; s.iord = 1; s.memw = 1; s.waits = 1; s.cnt = 1;
          s.stall = st_m; q.push_back(s);
        end
      end
      OP_R: begin
        alu_of(fn, ok, alu);
        s = blank(); s.srca = 1; s.alu = alu; s.alu_x = !ok; s.ill = !ok; q.push_back(s);
        if (ok) begin
          s = blank(); s.alu = 3'd2; s.regw = 1; s.rdst = 1; s.cnt = 1; q.push_back(s);
        end
      end
      OP_BEQ: begin
        s = blank(); s.srca = 1; s.alu = 3'd6; s.br = 1; s.pcsrc = 2'd1; s.cnt = 1;
        q.push_back(s);
      end
      OP_ADDI: begin
        s = blank(); s.srca = 1; s.srcb = 2'd2; s.alu = 3'd2; q.push_back(s);
        s = blank(); s.alu = 3'd2; s.regw = 1; s.cnt = 1; q.push_back(s);
      end
      default: begin // jump
        s = blank(); s.alu = 3'd2; s.pcsrc = 2'd2; s.pcw = 1; s.cnt = 1; q.push_back(s);
      end
    endcase
  endfunction

  // Hold reset for n cycles; entered and left just after a rising edge
  task automatic do_reset(input int n);
    rst = 1'b0;
    q.delete();
    cnt_m = '0;
    ex = blank(); ex.srcb = 2'd1; ex.alu = 3'd2;
    ex_pcen = 1'b0;
    chk_en = 1'b1;
    repeat (n) begin
      mem_ready = 1'($urandom_range(0, 1));
      Zero = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_instr_cnt", 32'(instr_cnt), 32'd0);
    rst = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int st_f,
                           input int st_m, input bit z, input int abort_at, output int len);
    step_t s;
    bit rdy, aborted;
    aborted = 1'b0;
    mw_seen = 0; ill_seen = 0; bt_seen = 0;
    build(op, fn, st_f, st_m);
    stall = q[0].stall;
    len = 0;
    while (q.size() > 0) begin
      if (len == abort_at) begin aborted = 1'b1; break; end
      s = q[0];
      if (s.waits) begin
        rdy = (stall == 0);
        if (stall > 0) stall--;
      end else rdy = 1'($urandom_range(0, 1));
      Op = op; Funct = fn; Zero = z; mem_ready = rdy;
      ex = s;
      if (s.waits && !rdy) begin ex.irw = 0; ex.pcw = 0; end
      ex_pcen = ex.pcw | (ex.br & z);
      chk_en = 1'b1;
      @(posedge clk); #1;
      len++;
      if (!s.waits || rdy) begin
        if (s.cnt) cnt_m++;
        void'(q.pop_front());
        if (q.size() > 0) stall = q[0].stall;
      end
    end
    if (aborted) do_reset(1 + int'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    logic [5:0] op, fn;
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'b111111, 6'b000000};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    @(posedge clk); #1;
    do_reset(2);

    run_instr(OP_R, 6'b100000, 0, 0, 1'b0, -1, len);
    chk("add_len", 32'(len), 32'd4);
    chk("add_cnt", 32'(instr_cnt), 32'd1);

    run_instr(OP_LW, 6'b000000, 0, 3, 1'b0, -1, len);
    chk("lw_len", 32'(len), 32'd8);

    run_instr(OP_SW, 6'b000000, 0, 2, 1'b0, -1, len);
    chk("sw_memwrite_cycles", 32'(mw_seen), 32'd3);
    chk("sw_len", 32'(len), 32'd6);
    chk("sw_cnt", 32'(instr_cnt), 32'd3);

    run_instr(OP_BEQ, 6'b000000, 1, 0, 1'b1, -1, len);
    chk("beq_taken", 32'(bt_seen), 32'd1);
    run_instr(OP_BEQ, 6'b000000, 0, 0, 1'b0, -1, len);
    chk("beq_not_taken", 32'(bt_seen), 32'd0);

    run_instr(6'b111111, 6'b100000, 0, 0, 1'b0, -1, len);
    chk("bad_op_pulses", 32'(ill_seen), 32'd1);
    chk("bad_op_len", 32'(len), 32'd2);
    chk("bad_op_cnt", 32'(instr_cnt), 32'd5);

    run_instr(OP_R, 6'b000000, 0, 0, 1'b0, -1, len);
    chk("bad_fn_pulses", 32'(ill_seen), 32'd1);
    chk("bad_fn_len", 32'(len), 32'd3);

    run_instr(OP_ADDI, 6'b000000, 0, 0, 1'b0, -1, len);
    chk("addi_len", 32'(len), 32'd4);
    chk("addi_cnt", 32'(instr_cnt), 32'd6);

    run_instr(OP_J, 6'b000000, 0, 0, 1'b0, -1, len);
`ifdef JUMP_EN
    chk("j_pulses", 32'(ill_seen), 32'd0);
    chk("j_cnt", 32'(instr_cnt), 32'd7);
`else
    chk("j_pulses", 32'(ill_seen), 32'd1);
    chk("j_cnt", 32'(instr_cnt), 32'd6);
`endif

    // reset arrives in the EXEC cycle of an add
    run_instr(OP_R, 6'b100000, 0, 0, 1'b0, 2, len);
    chk("abort_cnt", 32'(instr_cnt), 32'd0);

    for (int i = 0; i < 400; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 6'b000000 && $urandom_range(0, 3) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 5)) : -1, len);
    end

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
